// File: rtl/ps_loop_ctrl_pkg.sv
// Shared program-sequencer definitions: loop stack entry, sticky bit indices,
// and user-register addresses for loop status readback.
package ps_loop_ctrl_pkg;

   localparam int LP_ADDR_W = 16;
   localparam int LP_CNT_W  = 16;
   localparam int LP_PTR_W  = 3;

   localparam int LP_OVF = 0;
   localparam int LP_UNF = 1;

   localparam logic [7:0] UREG_LP_CUR_CNT = 8'h30;
   localparam logic [7:0] UREG_LP_STKY    = 8'h31;

   typedef struct packed {
      logic [LP_ADDR_W-1:0] top_addr;
      logic [LP_ADDR_W-1:0] end_addr;
      logic [LP_CNT_W-1:0]  cnt;
   } lp_ent_t;

   // A zero count still runs the body once.
   function automatic logic [LP_CNT_W-1:0] lp_cnt_norm(input logic [LP_CNT_W-1:0] c);
      return (c == '0) ? LP_CNT_W'(1) : c;
   endfunction

endpackage

// File: rtl/ps_loop_ctrl_if.sv
// Loop-controller bus: do-until decode, fetch observation and redirect/status.
interface ps_loop_ctrl_if
   import ps_loop_ctrl_pkg::*;
#(
   parameter int ADDR_W = LP_ADDR_W,
   parameter int CNT_W  = LP_CNT_W
);
   logic              lp_start;
   logic [ADDR_W-1:0] lp_top_addr;
   logic [ADDR_W-1:0] lp_end_addr;
   logic [CNT_W-1:0]  lp_cnt;
   logic              lp_pop;
   logic              lp_stky_clr;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_vld;
   logic              lp_jmp;
   logic [ADDR_W-1:0] lp_jmp_addr;
   logic [CNT_W-1:0]  lp_cur_cnt;
   logic [2:0]        lp_depth;
   logic              lp_empty;
   logic              lp_full;
   logic [1:0]        lp_stky;

   modport master (
      output lp_start, lp_top_addr, lp_end_addr, lp_cnt, lp_pop, lp_stky_clr,
             fetch_addr, fetch_vld,
      input  lp_jmp, lp_jmp_addr, lp_cur_cnt, lp_depth, lp_empty, lp_full, lp_stky
   );

   modport slave (
      input  lp_start, lp_top_addr, lp_end_addr, lp_cnt, lp_pop, lp_stky_clr,
             fetch_addr, fetch_vld,
      output lp_jmp, lp_jmp_addr, lp_cur_cnt, lp_depth, lp_empty, lp_full, lp_stky
   );

endinterface

// File: rtl/ps_loop_ctrl_lp_stack.sv
// DEPTH-entry loop LIFO with push, pop, replace-TOS and in-place TOS count update.
module lp_stack
   import ps_loop_ctrl_pkg::*;
#(
   parameter int DEPTH = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  lp_ent_t             din,
   input  logic                tos_wr,
   input  logic [LP_CNT_W-1:0] tos_cnt,
   output lp_ent_t             tos,
   output logic [LP_PTR_W-1:0] depth
);

   lp_ent_t             ent [DEPTH];
   logic [LP_PTR_W-1:0] top_idx;

   assign top_idx = depth - LP_PTR_W'(1);

   // Caller guarantees push only when not full or when popping in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         depth <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         if (push && pop) begin
            ent[top_idx] <= din;
         end else if (push) begin
            ent[depth] <= din;
            depth      <= depth + LP_PTR_W'(1);
         end else if (pop) begin
            depth <= top_idx;
         end
         if (tos_wr) ent[top_idx].cnt <= tos_cnt;
      end
   end

   always_comb begin
      tos = '0;
      if (depth != '0) tos = ent[top_idx];
   end

endmodule

// File: rtl/ps_loop_ctrl.sv
// Zero-overhead do-until loop controller: watches fetch, redirects to loop top
// at the innermost end address until that loop's count is exhausted.
module ps_loop_ctrl
   import ps_loop_ctrl_pkg::*;
#(
   parameter int ADDR_W = LP_ADDR_W,
   parameter int CNT_W  = LP_CNT_W,
   parameter int DEPTH  = 6
) (
   input logic          clk,
   input logic          rst,
   ps_loop_ctrl_if.slave lp
);

   lp_ent_t             tos;
   lp_ent_t             push_ent;
   logic [LP_PTR_W-1:0] depth;
   logic                empty, full;
   logic                hit, last, dec;
   logic                pop_any, push_ok;
   logic [CNT_W-1:0]    cnt_dec;
   logic [ADDR_W-1:0]   end_addr;
   logic [1:0]          stky, stky_set, stky_nxt;

   assign empty    = (depth == '0);
   assign full     = (depth == LP_PTR_W'(DEPTH));
   assign end_addr = tos.end_addr;

   assign hit  = lp.fetch_vld && !empty && (lp.fetch_addr == end_addr);
   assign last = (tos.cnt == CNT_W'(1));
   // An explicit pop in the hit cycle aborts the loop: no redirect, no decrement.
   assign dec  = hit && !last && !lp.lp_pop;

   assign pop_any = (lp.lp_pop && !empty) || (hit && last);
   assign push_ok = lp.lp_start && (!full || pop_any);
   assign cnt_dec = tos.cnt - CNT_W'(1);

   always_comb begin
      push_ent          = '0;
      push_ent.top_addr = lp.lp_top_addr;
      push_ent.end_addr = lp.lp_end_addr;
      push_ent.cnt      = lp_cnt_norm(lp.lp_cnt);
   end

   lp_stack #(.DEPTH(DEPTH)) u_stack (
      .clk     (clk),
      .rst     (rst),
      .push    (push_ok),
      .pop     (pop_any),
      .din     (push_ent),
      .tos_wr  (dec),
      .tos_cnt (cnt_dec),
      .tos     (tos),
      .depth   (depth)
   );

   always_comb begin
      stky_set         = '0;
      stky_set[LP_OVF] = lp.lp_start && full && !pop_any;
      stky_set[LP_UNF] = lp.lp_pop && empty;
      // Set wins over a coincident clear.
      stky_nxt         = (lp.lp_stky_clr ? 2'b00 : stky) | stky_set;
   end

   always_ff @(posedge clk) begin
      if (rst) stky <= '0;
      else     stky <= stky_nxt;
   end

   assign lp.lp_jmp      = dec;
   assign lp.lp_jmp_addr = tos.top_addr;
   assign lp.lp_cur_cnt  = tos.cnt;
   assign lp.lp_depth    = depth;
   assign lp.lp_empty    = empty;
   assign lp.lp_full     = full;
   assign lp.lp_stky     = stky;

endmodule

// File: tb/tb_ps_loop_ctrl.sv
// Scoreboard bench for ps_loop_ctrl: a reference loop-stack model queues the
// expected outputs for every driven cycle, which are then compared to the DUT.
module tb_ps_loop_ctrl;
   import ps_loop_ctrl_pkg::*;

   localparam int DEPTH = 6;

   typedef struct {
      logic        jmp;
      logic [15:0] addr;
      logic [15:0] cnt;
      logic [2:0]  dep;
      logic        emp;
      logic        full;
      logic [1:0]  stky;
   } exp_t;

   logic clk, rst;
   ps_loop_ctrl_if #(.ADDR_W(16), .CNT_W(16)) lp_if ();

   ps_loop_ctrl #(.ADDR_W(16), .CNT_W(16), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .lp  (lp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] m_top[DEPTH];
   logic [15:0] m_end[DEPTH];
   logic [15:0] m_cnt[DEPTH];
   int          m_dep = 0;
   logic [1:0]  m_stky = 2'b00;
   logic        obs_jmp;
   logic [15:0] obs_addr, obs_cnt;
   int          obs_dep;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic st, input logic [15:0] t, input logic [15:0] e,
                       input logic [15:0] c, input logic pp, input logic clr,
                       input logic [15:0] fa, input logic fv);
      exp_t       x, y;
      int         ti;
      logic       emp, hit, lastc, popping;
      logic [1:0] ns;
      @(negedge clk);
      rst                = r;
      lp_if.lp_start     = st;
      lp_if.lp_top_addr  = t;
      lp_if.lp_end_addr  = e;
      lp_if.lp_cnt       = c;
      lp_if.lp_pop       = pp;
      lp_if.lp_stky_clr  = clr;
      lp_if.fetch_addr   = fa;
      lp_if.fetch_vld    = fv;
      emp    = (m_dep == 0);
      ti     = emp ? 0 : m_dep - 1;
      hit    = fv && !emp && (fa == m_end[ti]);
      lastc  = !emp && (m_cnt[ti] == 16'd1);
      x.jmp  = hit && !lastc && !pp;
      x.addr = emp ? 16'h0 : m_top[ti];
      x.cnt  = emp ? 16'h0 : m_cnt[ti];
      x.dep  = 3'(m_dep);
      x.emp  = emp;
      x.full = (m_dep == DEPTH);
      x.stky = m_stky;
      sb.push_back(x);
      #1;
      y = sb.pop_front();
      chk("lp_jmp",      32'(lp_if.lp_jmp),      32'(y.jmp));
      chk("lp_jmp_addr", 32'(lp_if.lp_jmp_addr), 32'(y.addr));
      chk("lp_cur_cnt",  32'(lp_if.lp_cur_cnt),  32'(y.cnt));
      chk("lp_depth",    32'(lp_if.lp_depth),    32'(y.dep));
      chk("lp_empty",    32'(lp_if.lp_empty),    32'(y.emp));
      chk("lp_full",     32'(lp_if.lp_full),     32'(y.full));
      chk("lp_stky",     32'(lp_if.lp_stky),     32'(y.stky));
      obs_jmp  = lp_if.lp_jmp;
      obs_addr = lp_if.lp_jmp_addr;
      obs_cnt  = lp_if.lp_cur_cnt;
      obs_dep  = int'(lp_if.lp_depth);
      // advance the model across the coming rising edge
      if (r) begin
         m_dep  = 0;
         m_stky = 2'b00;
         for (int i = 0; i < DEPTH; i++) begin
            m_top[i] = 16'h0; m_end[i] = 16'h0; m_cnt[i] = 16'h0;
         end
      end else begin
         popping = (pp && !emp) || (hit && lastc);
         if (x.jmp) m_cnt[ti] = m_cnt[ti] - 16'd1;
         ns = clr ? 2'b00 : m_stky;
         if (st && (m_dep == DEPTH) && !popping) ns[0] = 1'b1;
         if (pp && emp) ns[1] = 1'b1;
         m_stky = ns;
         if (st && popping) begin
            m_top[ti] = t; m_end[ti] = e; m_cnt[ti] = (c == 16'h0) ? 16'd1 : c;
         end else if (st && (m_dep < DEPTH)) begin
            m_top[m_dep] = t; m_end[m_dep] = e; m_cnt[m_dep] = (c == 16'h0) ? 16'd1 : c;
            m_dep++;
         end else if (popping) begin
            m_dep--;
         end
      end
   endtask

   task automatic idle(input logic [15:0] fa, input logic fv);
      step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, fa, fv);
   endtask

   task automatic push_lp(input logic [15:0] t, input logic [15:0] e, input logic [15:0] c,
                          input logic [15:0] fa, input logic fv);
      step(1'b0, 1'b1, t, e, c, 1'b0, 1'b0, fa, fv);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] pc;
      int          k, jumps, v_in, v_out, prev;
      int          dq[$];
      int          dexp[6];
      for (int i = 0; i < DEPTH; i++) begin
         m_top[i] = 16'h0; m_end[i] = 16'h0; m_cnt[i] = 16'h0;
      end
      rst = 1'b1;
      lp_if.lp_start = 1'b0; lp_if.lp_top_addr = '0; lp_if.lp_end_addr = '0; lp_if.lp_cnt = '0;
      lp_if.lp_pop = 1'b0; lp_if.lp_stky_clr = 1'b0; lp_if.fetch_addr = '0; lp_if.fetch_vld = 1'b0;
      step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      idle(16'h0, 1'b0);
      chk("reset_empty", 32'(lp_if.lp_empty), 32'd1);

      // single loop
      push_lp(16'h10, 16'h13, 16'd3, 16'h0F, 1'b1);
      pc = 16'h10; k = 0; jumps = 0; v_in = 0;
      while (pc != 16'h14 && k < 40) begin
         if (pc == 16'h10) v_in++;
         idle(pc, 1'b1);
         if (obs_jmp) begin jumps++; pc = obs_addr; end
         else pc = pc + 16'd1;
         k++;
      end
      chk("single_end_pc", 32'(pc), 32'h14);
      chk("single_jumps",  32'(jumps), 32'd2);
      chk("single_body",   32'(v_in), 32'd3);
      idle(16'h14, 1'b1);
      chk("single_depth",  32'(obs_dep), 32'd0);

      // nested loops
      push_lp(16'h20, 16'h28, 16'd2, 16'h1F, 1'b1);
      pc = 16'h20; k = 0; v_in = 0; v_out = 0; prev = -1;
      while (pc != 16'h29 && k < 100) begin
         if (pc == 16'h22) v_in++;
         if (pc == 16'h20) v_out++;
         step(1'b0, pc == 16'h21, 16'h22, 16'h24, 16'd3, 1'b0, 1'b0, pc, 1'b1);
         if (obs_dep != prev) begin dq.push_back(obs_dep); prev = obs_dep; end
         if (obs_jmp) pc = obs_addr;
         else pc = pc + 16'd1;
         k++;
      end
      idle(16'h29, 1'b1);
      if (obs_dep != prev) dq.push_back(obs_dep);
      chk("nest_end_pc", 32'(pc), 32'h29);
      chk("nest_inner",  32'(v_in), 32'd6);
      chk("nest_outer",  32'(v_out), 32'd2);
      dexp = '{1, 2, 1, 2, 1, 0};
      chk("nest_dseq_len", 32'(dq.size()), 32'd6);
      for (int i = 0; i < 6 && i < dq.size(); i++) chk("nest_dseq", 32'(dq[i]), 32'(dexp[i]));

      // overflow
      for (int i = 0; i < 6; i++)
         push_lp(16'h100 + 16'(i * 4), 16'h102 + 16'(i * 4), 16'd2, 16'h0, 1'b0);
      push_lp(16'h180, 16'h182, 16'd2, 16'h0, 1'b0);
      idle(16'h0, 1'b0);
      chk("ovf_full",  32'(lp_if.lp_full), 32'd1);
      chk("ovf_depth", 32'(obs_dep), 32'd6);
      chk("ovf_tos",   32'(obs_addr), 32'h114);
      chk("ovf_stky",  32'(lp_if.lp_stky), 32'b01);
      step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0);
      idle(16'h0, 1'b0);
      chk("ovf_clr", 32'(lp_if.lp_stky), 32'b00);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

      // underflow, and aborting an active loop
      step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      idle(16'h0, 1'b0);
      chk("unf_stky",  32'(lp_if.lp_stky), 32'b10);
      chk("unf_depth", 32'(obs_dep), 32'd0);
      step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0);
      push_lp(16'h40, 16'h42, 16'd5, 16'h3F, 1'b1);
      idle(16'h40, 1'b1);
      step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h41, 1'b1);
      idle(16'h42, 1'b1);
      chk("abort_nojmp", 32'(obs_jmp), 32'd0);
      push_lp(16'h40, 16'h42, 16'd5, 16'h42, 1'b1);
      idle(16'h40, 1'b1);
      idle(16'h41, 1'b1);
      step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h42, 1'b1);
      chk("abort_hit_nojmp", 32'(obs_jmp), 32'd0);
      idle(16'h43, 1'b1);
      chk("abort_hit_depth", 32'(obs_dep), 32'd0);
      chk("abort_hit_stky",  32'(lp_if.lp_stky), 32'b00);

      // zero count and stalls
      push_lp(16'h50, 16'h51, 16'd0, 16'h4F, 1'b1);
      idle(16'h50, 1'b1);
      chk("zero_cnt", 32'(obs_cnt), 32'd1);
      idle(16'h51, 1'b1);
      chk("zero_nojmp", 32'(obs_jmp), 32'd0);
      push_lp(16'h60, 16'h61, 16'd2, 16'h52, 1'b1);
      chk("zero_popped", 32'(obs_dep), 32'd0);
      idle(16'h61, 1'b0);
      chk("stall_nojmp", 32'(obs_jmp), 32'd0);
      idle(16'h61, 1'b0);
      chk("stall_cnt", 32'(obs_cnt), 32'd2);
      idle(16'h61, 1'b1);
      chk("stall_resume_jmp", 32'(obs_jmp), 32'd1);
      idle(16'h60, 1'b1);
      chk("stall_dec", 32'(obs_cnt), 32'd1);
      idle(16'h61, 1'b1);
      chk("stall_fall", 32'(obs_jmp), 32'd0);

      // reset mid-loop
      push_lp(16'h70, 16'h72, 16'd4, 16'h6F, 1'b1);
      pc = 16'h70; k = 0;
      do begin
         idle(pc, 1'b1);
         if (obs_jmp) pc = obs_addr;
         else pc = pc + 16'd1;
         k++;
      end while (obs_cnt != 16'd2 && k < 20);
      chk("rst_reach_cnt2", 32'(obs_cnt), 32'd2);
      step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, pc, 1'b1);
      idle(16'h72, 1'b1);
      chk("rst_depth", 32'(obs_dep), 32'd0);
      chk("rst_nojmp", 32'(obs_jmp), 32'd0);

      // replace TOS on a terminal pop while full
      for (int i = 0; i < 5; i++)
         push_lp(16'h200 + 16'(i * 4), 16'h202 + 16'(i * 4), 16'd3, 16'h0, 1'b0);
      push_lp(16'h80, 16'h81, 16'd1, 16'h0, 1'b0);
      step(1'b0, 1'b1, 16'h90, 16'h95, 16'd7, 1'b0, 1'b0, 16'h81, 1'b1);
      chk("repl_nojmp", 32'(obs_jmp), 32'd0);
      idle(16'h0, 1'b0);
      chk("repl_depth", 32'(obs_dep), 32'd6);
      chk("repl_top",   32'(obs_addr), 32'h90);
      chk("repl_cnt",   32'(obs_cnt), 32'd7);
      chk("repl_stky",  32'(lp_if.lp_stky), 32'b00);

      // random mix against the model
      for (int i = 0; i < 400; i++)
         step(($urandom % 64) == 0, ($urandom % 4) == 0, 16'($urandom % 16), 16'($urandom % 8),
              16'($urandom % 4), ($urandom % 8) == 0, ($urandom % 16) == 0,
              16'($urandom % 8), ($urandom % 4) != 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ps_loop_ctrl.md
# ps_loop_ctrl

Hardware loop controller for the program sequencer. It keeps a loop stack of DEPTH entries; each entry holds a top address, an end address and an iteration count. It watches the fetch address every cycle. When the fetch address reaches the end address of the innermost loop, it redirects fetch back to the top until the count is used up. It sits beside the fetch-address counter and drives the next-fetch-address mux, so do-until loops run with zero overhead.

## Interface
Parameters:
- ADDR_W, 16, program memory address width
- CNT_W, 16, loop counter width
- DEPTH, 6, number of loop stack entries

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset; synchronous, active-high
- lp_start  in  1  decoded do-until instruction, valid for one cycle
- lp_top_addr  in  ADDR_W  address of the first loop-body instruction
- lp_end_addr  in  ADDR_W  address of the last loop-body instruction
- lp_cnt  in  CNT_W  iteration count
- lp_pop  in  1  explicit pop of the loop stack (loop abort)
- lp_stky_clr  in  1  clears the sticky error bits
- fetch_addr  in  ADDR_W  current fetch address
- fetch_vld  in  1  fetch advances this cycle (low = stalled)
- lp_jmp  out  1  redirect the next fetch to lp_jmp_addr
- lp_jmp_addr  out  ADDR_W  top address of the innermost loop
- lp_cur_cnt  out  CNT_W  remaining count of the innermost loop
- lp_depth  out  3  number of occupied entries (0..DEPTH)
- lp_empty  out  1  stack is empty
- lp_full  out  1  stack is full
- lp_stky  out  2  sticky bits: [0] overflow, [1] underflow

## Operation
- The stack is an array of {top, end, cnt} entries with pointer lp_depth. Only the top-of-stack (TOS) entry is ever compared.
- **Push** (lp_start): writes {lp_top_addr, lp_end_addr, lp_cnt} at index lp_depth, then lp_depth+1. An lp_cnt of 0 is stored as 1, so the body executes once.
- **Terminal hit**: the cycle where fetch_vld, !lp_empty and fetch_addr == TOS.end all hold.
  - TOS.cnt != 1: lp_jmp=1 and TOS.cnt decrements by 1.
  - TOS.cnt == 1: lp_jmp=0 (fall through) and the entry pops.
- **Explicit pop** (lp_pop, stack not empty): removes TOS with no jump.
  - If a hit occurs in the same cycle, lp_jmp is forced to 0 and there is a single pop.
- **Pop and push in the same cycle** (a hit-pop or lp_pop together with lp_start): TOS is replaced by the new entry and lp_depth is unchanged. This is allowed even when the stack is full.
- **Overflow**: lp_start while full with no same-cycle pop. The push is dropped and lp_stky[0] sets.
- **Underflow**: lp_pop while empty. It has no effect and lp_stky[1] sets.
- **Sticky bits**: hold until lp_stky_clr. If set and clear coincide, set wins.
- **Nesting rule**: nested loops must use distinct end addresses. When several loops share an end address, only the innermost loop terminates correctly.
- **Stalls**: with fetch_vld low, there is no hit, no decrement and lp_jmp=0. Pushes and pops are still honoured.

## Timing
- lp_jmp, lp_jmp_addr and lp_cur_cnt are combinational from the TOS registers and fetch_addr. The redirect takes effect at the same edge as the fetch-counter update, so no bubble is inserted.
- A pushed entry becomes comparable from the cycle after lp_start. A hit in the lp_start cycle acts on the previous TOS.
- Counter decrement and stack pointer updates happen at the rising clk edge.
- Reset values: lp_depth=0, all entries 0, lp_empty=1, lp_full=0, lp_jmp=0, lp_jmp_addr=0, lp_cur_cnt=0, lp_stky=0.
- rst asserted mid-loop empties the stack at the next edge. lp_jmp is 0 from the cycle after reset.
- lp_full = (lp_depth == DEPTH) and lp_empty = (lp_depth == 0), both decoded from registered state.

## Structure
- Shared sequencer package holds:
  - the loop entry struct {top, end, cnt}
  - the sticky bit index constants (LP_OVF=0, LP_UNF=1)
  - the PS ureg addresses that will later expose lp_cur_cnt and lp_stky for reads
- One sub-module, `lp_stack`: the DEPTH-entry LIFO with push/pop/replace and TOS output. The hit logic, counter decrement and flags stay in ps_loop_ctrl.

## Test plan
- **Single loop**: start top=0x10, end=0x13, cnt=3; fetch increments from 0x10 → lp_jmp to 0x10 at 0x13 twice; third hit falls through to 0x14; lp_depth ends at 0.
- **Nested loops**: outer top=0x20, end=0x28, cnt=2; inner top=0x22, end=0x24, cnt=3 → inner body runs 3 times per outer pass (6 total) and the outer body runs 2 times; lp_depth sequence is 1, 2, 1, 2, 1, 0.
- **Overflow**: 6 pushes followed by a 7th → lp_full=1, 7th push dropped, lp_stky=2'b01; lp_stky_clr → 0.
- **Underflow**: lp_pop on an empty stack → lp_stky=2'b10, lp_depth stays 0. lp_pop during an active loop → next hit at the end address gives lp_jmp=0.
- **Stalls and zero count**: cnt=0 → body once, no jump; fetch_vld low while fetch_addr equals the end address → no decrement, lp_jmp=0.
- **Reset and replace**: rst mid-loop at cnt=2 → lp_depth=0, lp_jmp=0 the next cycle. lp_start coinciding with a terminal pop while full → lp_depth stays 6, TOS equals the new entry, no overflow.
